// File: rtl/reg_dump_if.sv
// rtl/reg_dump_if.sv - register-file read port and dump output stream
interface reg_dump_if #(
    parameter int DATA_W = 32
);
    logic [4:0]        rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        out_addr;
    logic [DATA_W-1:0] out_data;

    modport master (
        output rd_addr,
        input  rd_data,
        output out_valid,
        input  out_ready,
        output out_addr,
        output out_data
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  out_valid,
        output out_ready,
        input  out_addr,
        input  out_data
    );
endinterface

// File: rtl/reg_dump.sv
// rtl/reg_dump.sv - sequential register-file dumper with valid/ready output
module reg_dump #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 32
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    reg_dump_if.master bus,
    output logic       busy,
    output logic       done
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [4:0] LAST_ADDR = 5'(NUM_REGS - 1);

    logic [1:0]        state_q, state_d;
    logic [4:0]        rd_addr_q, rd_addr_d;
    logic [4:0]        out_addr_q, out_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              done_q, done_d;

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_ADDR;
                    rd_addr_d = '0;
                end
            end
            S_ADDR: begin
                // rd_addr has been stable all cycle, so rd_data is settled here
                out_data_d  = bus.rd_data;
                out_addr_d  = rd_addr_q;
                out_valid_d = 1'b1;
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (rd_addr_q == LAST_ADDR) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        rd_addr_d = rd_addr_q + 5'd1;
                        state_d   = S_ADDR;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // abort overrides any handshake this cycle; the word counts as undelivered
        if (state_q != S_IDLE && abort) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            done_d      = 1'b0;
            rd_addr_d   = '0;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rd_addr_q   <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign bus.rd_addr   = rd_addr_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
endmodule

// File: tb/tb_reg_dump.sv
// tb/tb_reg_dump.sv - self-checking bench for reg_dump
module tb_reg_dump;
    logic clock_in;
    logic reset;
    logic start;
    logic abort;
    logic busy;
    logic done;
    logic [31:0] regs [0:15];

    int errors = 0;
    int checks = 0;

    reg_dump_if #(.DATA_W(32)) bus ();

    reg_dump #(.NUM_REGS(16), .DATA_W(32)) dut (
        .clock_in (clock_in),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .bus      (bus),
        .busy     (busy),
        .done     (done)
    );

    assign bus.rd_data = (bus.rd_addr < 5'd16) ? regs[bus.rd_addr[3:0]] : 32'h0;

    initial begin
        clock_in = 1'b0;
        forever #5 clock_in = ~clock_in;
    end

    typedef struct {
        logic       start;
        logic       abort;
        logic       ready;
        logic       exp_busy;
        logic       exp_valid;
        logic [4:0] exp_rd_addr;
        logic [4:0] exp_out_addr;
        logic       exp_done;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_regs();
        for (int i = 0; i < 16; i++) regs[i] = 32'(i);
    endtask

    // phase 1: wait for ADDR of word a; phase 0: wait for word a valid
    task automatic wait_word(input logic [4:0] a, input bit addr_phase);
        bit hit = 0;
        for (int n = 0; n < 200 && !hit; n++) begin
            if (addr_phase) hit = busy && !bus.out_valid && bus.rd_addr == a && !done;
            else            hit = bus.out_valid && bus.out_addr == a;
            if (!hit) @(negedge clock_in);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_word: word %0d never reached (phase %0d)", a, addr_phase);
        end
    endtask

    task automatic clean_abort();
        abort = 1'b1;
        @(negedge clock_in);
        abort = 1'b0;
        chk("abort_idle", busy, 0);
    endtask

    initial begin
        int exp_idx, done_cnt, since;
        bit prev_valid, prev_accept, finished, hold;
        logic [4:0] prev_addr;
        logic [31:0] prev_data;

        tbl[0] = '{1, 0, 0, 1, 0, 5'd0, 5'd0, 0};
        tbl[1] = '{0, 0, 0, 1, 1, 5'd0, 5'd0, 0};
        tbl[2] = '{0, 0, 0, 1, 1, 5'd0, 5'd0, 0};
        tbl[3] = '{1, 0, 1, 1, 0, 5'd1, 5'd0, 0};
        tbl[4] = '{0, 0, 1, 1, 1, 5'd1, 5'd1, 0};
        tbl[5] = '{0, 1, 1, 0, 0, 5'd0, 5'd0, 0};
        tbl[6] = '{1, 1, 0, 1, 0, 5'd0, 5'd0, 0};
        tbl[7] = '{0, 0, 0, 1, 1, 5'd0, 5'd0, 0};

        reset_regs();
        reset = 1'b1; start = 1'b1; abort = 1'b0; bus.out_ready = 1'b1;
        @(negedge clock_in);
        @(negedge clock_in);
        chk("rst_busy", busy, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_addr", bus.rd_addr, 0);
        chk("rst_out_addr", bus.out_addr, 0);
        chk("rst_out_data", bus.out_data, 0);
        reset = 1'b0; start = 1'b0;
        for (int n = 0; n < 3; n++) @(negedge clock_in);
        chk("idle_hold", busy, 0);

        // table-driven control corner cases
        for (int i = 0; i < 8; i++) begin
            start = tbl[i].start; abort = tbl[i].abort; bus.out_ready = tbl[i].ready;
            @(negedge clock_in);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
            chk($sformatf("tbl%0d_valid", i), bus.out_valid, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_rd_addr", i), bus.rd_addr, tbl[i].exp_rd_addr);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].exp_done);
            if (tbl[i].exp_valid) begin
                chk($sformatf("tbl%0d_out_addr", i), bus.out_addr, tbl[i].exp_out_addr);
                chk($sformatf("tbl%0d_out_data", i), bus.out_data, 32'(tbl[i].exp_out_addr));
            end
        end
        start = 1'b0;
        clean_abort();

        // full dumps with ready high; second pass hammers start while busy
        for (int pass = 0; pass < 2; pass++) begin
            bus.out_ready = 1'b1; start = 1'b1;
            @(negedge clock_in);
            for (int n = 1; n <= 34; n++) begin
                bit ev;
                start = (pass == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                ev = (n % 2 == 0) && n >= 2 && n <= 32;
                chk($sformatf("full%0d_c%0d_valid", pass, n), bus.out_valid, ev);
                chk($sformatf("full%0d_c%0d_done", pass, n), done, n == 33);
                chk($sformatf("full%0d_c%0d_busy", pass, n), busy, n <= 33);
                if (ev) begin
                    chk($sformatf("full%0d_c%0d_addr", pass, n), bus.out_addr, n / 2 - 1);
                    chk($sformatf("full%0d_c%0d_data", pass, n), bus.out_data, n / 2 - 1);
                end
                if (n == 33) chk("full_rd_addr_no_wrap", bus.rd_addr, 15);
                if (n < 34) @(negedge clock_in);
            end
            start = 1'b0;
        end

        // stall on word 3 for 5 cycles
        start = 1'b1; bus.out_ready = 1'b1;
        @(negedge clock_in);
        start = 1'b0;
        wait_word(5'd3, 1'b0);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d", k), {bus.out_valid, bus.out_addr, bus.out_data}, {1'b1, 5'd3, 32'h3});
            @(negedge clock_in);
        end
        chk("stall_end", {bus.out_valid, bus.out_addr, bus.out_data}, {1'b1, 5'd3, 32'h3});
        bus.out_ready = 1'b1;
        @(negedge clock_in);
        chk("stall_gap", bus.out_valid, 0);
        @(negedge clock_in);
        chk("stall_next", {bus.out_valid, bus.out_addr, bus.out_data}, {1'b1, 5'd4, 32'h4});
        clean_abort();

        // abort during SEND of word 7, coincident with a handshake
        start = 1'b1;
        @(negedge clock_in);
        start = 1'b0;
        wait_word(5'd7, 1'b0);
        abort = 1'b1;
        @(negedge clock_in);
        abort = 1'b0;
        chk("abort7_state", {busy, bus.out_valid, bus.rd_addr, done}, {1'b0, 1'b0, 5'd0, 1'b0});
        for (int k = 0; k < 4; k++) begin
            @(negedge clock_in);
            chk("abort7_no_done", {busy, done}, 2'b00);
        end
        start = 1'b1;
        @(negedge clock_in);
        start = 1'b0;
        @(negedge clock_in);
        chk("restart_first", {bus.out_valid, bus.out_addr}, {1'b1, 5'd0});
        clean_abort();

        // reset in ADDR of word 10
        start = 1'b1;
        @(negedge clock_in);
        start = 1'b0;
        wait_word(5'd10, 1'b1);
        reset = 1'b1;
        @(negedge clock_in);
        reset = 1'b0;
        chk("rst10_outs", {busy, done, bus.out_valid, bus.rd_addr, bus.out_addr, bus.out_data},
            {1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0});
        for (int k = 0; k < 3; k++) begin
            @(negedge clock_in);
            chk("rst10_stays_idle", {busy, done}, 2'b00);
        end

        // register write on the negedge before word-5 capture
        start = 1'b1;
        @(negedge clock_in);
        start = 1'b0;
        wait_word(5'd5, 1'b1);
        regs[5] = 32'hDEADBEEF;
        @(negedge clock_in);
        chk("wr5_capture", {bus.out_valid, bus.out_addr, bus.out_data}, {1'b1, 5'd5, 32'hDEADBEEF});
        reset_regs();
        clean_abort();

        // randomized ready/start against a word-queue scoreboard
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < 16; i++) regs[i] = $urandom;
            exp_idx = 0; done_cnt = 0; since = 0;
            prev_valid = 0; prev_accept = 0; finished = 0;
            prev_addr = '0; prev_data = '0;
            start = 1'b1; bus.out_ready = 1'b0;
            for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
                @(negedge clock_in);
                since++;
                hold = prev_valid && !prev_accept;
                if (hold)
                    chk("rand_hold", {bus.out_valid, bus.out_addr, bus.out_data}, {1'b1, prev_addr, prev_data});
                if (done) begin
                    done_cnt++;
                    chk("rand_done_after_last", exp_idx, 16);
                    finished = 1;
                end
                if (bus.out_valid && !hold) begin
                    chk("rand_addr", bus.out_addr, exp_idx);
                    chk("rand_data", bus.out_data, regs[exp_idx[3:0]]);
                    chk("rand_gap", since, 2);
                end
                bus.out_ready = 1'($urandom_range(0, 1));
                start = ($urandom_range(0, 3) == 0);
                prev_accept = bus.out_valid && bus.out_ready;
                prev_valid = bus.out_valid;
                prev_addr = bus.out_addr;
                prev_data = bus.out_data;
                if (prev_accept) begin
                    exp_idx++;
                    since = 0;
                end
            end
            start = 1'b0;
            chk("rand_done_once", done_cnt, 1);
            @(negedge clock_in);
            chk("rand_idle_after", {busy, done}, 2'b00);
        end
        reset_regs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 Parameter NUM_REGS, default 16; number of register-file entries scanned, addresses 0..NUM_REGS-1.
REQ-002 Parameter DATA_W, default 32; register word width.
REQ-003 clock_in  input  1  system clock; all state changes on posedge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  begin dump; sampled only in IDLE.
REQ-006 abort  input  1  cancel dump; sampled in every non-IDLE state.
REQ-007 rd_addr  output  5  read-port address to register file; registered.
REQ-008 rd_data  input  DATA_W  register-file read data; combinational response to rd_addr.
REQ-009 out_valid  output  1  out_addr/out_data hold a valid word.
REQ-010 out_ready  input  1  sink accepts word when high together with out_valid at a posedge.
REQ-011 out_addr  output  5  index of the word on out_data.
REQ-012 out_data  output  DATA_W  captured register value.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-015 FSM states: IDLE, ADDR, SEND, DONE; one-hot or binary encoding, no other reachable states.
REQ-016 IDLE: start=1 -> ADDR, rd_addr<=0; start=0 -> stay IDLE.
REQ-017 ADDR: rd_addr stable for the full cycle; at posedge out_data<=rd_data, out_addr<=rd_addr, out_valid<=1 -> SEND.
REQ-018 SEND: out_valid, out_addr, out_data held constant until handshake (out_valid & out_ready at posedge).
REQ-019 SEND handshake with rd_addr < NUM_REGS-1: out_valid<=0, rd_addr<=rd_addr+1 -> ADDR.
REQ-020 SEND handshake with rd_addr = NUM_REGS-1: out_valid<=0, done<=1 -> DONE; rd_addr does not increment or wrap.
REQ-021 DONE: done<=0 -> IDLE unconditionally; start in DONE ignored.
REQ-022 Latency: first out_valid high 2 cycles after start sampled; each word costs 2 cycles minimum; with out_ready held high, full dump of 16 words: done high in cycle 33 after start edge, IDLE in cycle 34.
REQ-023 out_ready low in SEND: stall indefinitely, no timeout, no data change.
REQ-024 start while busy: ignored, no restart, no counter change.
REQ-025 abort=1 in ADDR, SEND or DONE: next posedge -> IDLE, out_valid<=0, done<=0, rd_addr<=0; no done pulse for aborted dump.
REQ-026 abort has priority over handshake in the same cycle; word is treated as not delivered.
REQ-027 start and abort both high in IDLE: start wins, dump begins.
REQ-028 out_valid never high in IDLE, ADDR or DONE.
REQ-029 Register-file writes occur on negedge; rd_data is sampled only at posedge in ADDR, so a write in the preceding negedge is visible in the captured value.

Reset
REQ-030 reset=1 at posedge: state<=IDLE, rd_addr<=0, out_addr<=0, out_data<=0, out_valid<=0, done<=0; busy=0.
REQ-031 reset has priority over start, abort and handshake; reset mid-dump discards progress, no done pulse.
REQ-032 After reset release, the block stays in IDLE until start is sampled high.

Verification
REQ-033 Register file at reset values (entry i = i), out_ready=1, pulse start -> 16 words, out_addr 0..15, out_data 0x0..0xF, each valid exactly 1 cycle, done pulse at cycle 33.
REQ-034 out_ready low for 5 cycles while word 3 valid -> out_addr=3, out_data=0x3 held all 5 cycles; word 4 follows 2 cycles after acceptance.
REQ-035 Abort during SEND of word 7 -> IDLE next cycle, out_valid=0, rd_addr=0, no done; new start restarts at out_addr 0.
REQ-036 Reset asserted in ADDR of word 10 -> all outputs 0 next cycle; busy=0; no done.
REQ-037 start pulsed repeatedly during dump -> sequence unchanged, exactly one done.
REQ-038 Write 0xDEADBEEF to entry 5 on negedge before word-5 ADDR capture -> out_data=0xDEADBEEF for out_addr 5.
